iot_riscv_muldiv: RTL

Parametrised multiply/divide unit implementing the full RISC-V M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind a valid/ready request interface. It sits beside the integer ALU in the execute stage. The ALU stalls EX while this unit is busy and takes its registered result. Compared with the previous-generation combined ALU multiplier/divider, it adds:
- configurable width;
- selectable native or sequential multiplier;
- architecturally correct divide-by-zero and signed-overflow results;
- a DIV/REM result cache;
- pipeline kill.

---
 rtl/iot_riscv_muldiv_pkg.sv | 18 +
 rtl/iot_riscv_muldiv_if.sv | 17 +
 rtl/iot_riscv_muldiv_div.sv | 43 ++++
 rtl/iot_riscv_muldiv.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/iot_riscv_muldiv_pkg.sv
// Shared encodings for the RISC-V M-extension multiply/divide unit.
// Ops follow funct3; states drive the unit's FSM.
package iot_riscv_pkg;
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // State names carry ST_ where they would otherwise clash with op names
    localparam logic [1:0] MD_IDLE   = 2'd0;
    localparam logic [1:0] MD_ST_MUL = 2'd1;
    localparam logic [1:0] MD_ST_DIV = 2'd2;
    localparam logic [1:0] MD_DONE   = 2'd3;
endpackage

// File: rtl/iot_riscv_muldiv_if.sv
// Request/response bundle between the EX-stage ALU and the muldiv unit.
interface iot_riscv_muldiv_if #(parameter int width_p = 32);
    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         op_i;
    logic [width_p-1:0] opa_i;
    logic [width_p-1:0] opb_i;
    logic               kill_i;
    logic               res_valid_o;
    logic [width_p-1:0] res_o;
    logic               busy_o;

    modport master (output req_valid_i, op_i, opa_i, opb_i, kill_i,
                    input  req_ready_o, res_valid_o, res_o, busy_o);
    modport slave  (input  req_valid_i, op_i, opa_i, opb_i, kill_i,
                    output req_ready_o, res_valid_o, res_o, busy_o);
endinterface

// File: rtl/iot_riscv_muldiv_div.sv
// Restoring division core on unsigned magnitudes, one quotient bit per step.
// quo_o/rem_o show the result of the step in progress so the caller can latch the final value on the last step edge.
module iot_riscv_muldiv_div #(parameter int width_p = 32) (
    input  logic               clk_i,
    input  logic               rst_an_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [width_p-1:0] divisor_i,
    input  logic [width_p-1:0] dividend_i,
    output logic [width_p-1:0] quo_o,
    output logic [width_p-1:0] rem_o
);
    logic [width_p-1:0] dvs_q, quo_q, rem_q;
    logic [width_p:0]   shl, diff;

    // Partial remainder is always below the divisor, so width_p+1 bits hold the shift and the borrow
    always_comb begin
        shl  = {rem_q, quo_q[width_p-1]};
        diff = shl - {1'b0, dvs_q};
        if (diff[width_p]) begin
            rem_o = shl[width_p-1:0];
            quo_o = {quo_q[width_p-2:0], 1'b0};
        end else begin
            rem_o = diff[width_p-1:0];
            quo_o = {quo_q[width_p-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            dvs_q <= divisor_i;
            quo_q <= dividend_i;
            rem_q <= '0;
        end else if (step_i) begin
            quo_q <= quo_o;
            rem_q <= rem_o;
        end
    end
endmodule

// File: rtl/iot_riscv_muldiv.sv
// RISC-V M-extension multiply/divide unit: FSM, sign handling, special cases,
// DIV/REM result cache and a native or sequential multiplier.
module iot_riscv_muldiv
    import iot_riscv_pkg::*;
#(
    parameter int width_p   = 32,
    parameter bit mul_seq_p = 1'b0
) (
    input logic              main_clk_i,
    input logic              main_rst_an_i,
    iot_riscv_muldiv_if.slave md
);
    localparam int CW = $clog2(width_p + 1);
    localparam logic [width_p-1:0] SMIN = {1'b1, {(width_p-1){1'b0}}};

    logic [1:0]         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic [width_p-1:0] opa_q, opb_q, res_q;
    logic               neg_q, rneg_q, res_vld_q;
    logic               c_vld_q, c_s_q;
    logic [width_p-1:0] c_a_q, c_b_q, c_q_q, c_r_q;

    logic               is_mul, div_sgn, is_rem, sgn_a, sgn_b, a_neg, b_neg;
    logic               div_zero, div_ovf, c_hit;
    logic [width_p-1:0] a_mag, b_mag, fast_res, q_nxt, r_nxt, q_fin, r_fin;
    logic [width_p-1:0] mul_now, mul_fin;

    always_comb begin
        is_mul  = ~md.op_i[2];
        div_sgn = ~md.op_i[0];
        is_rem  = md.op_i[1];
        sgn_a   = is_mul ? (md.op_i != MD_MULHU) : div_sgn;
        sgn_b   = is_mul ? (md.op_i == MD_MUL || md.op_i == MD_MULH) : div_sgn;
        a_neg   = sgn_a & md.opa_i[width_p-1];
        b_neg   = sgn_b & md.opb_i[width_p-1];
        a_mag   = a_neg ? -md.opa_i : md.opa_i;
        b_mag   = b_neg ? -md.opb_i : md.opb_i;
        div_zero = (md.opb_i == '0);
        div_ovf  = div_sgn & (md.opa_i == SMIN) & (md.opb_i == '1);
        c_hit    = c_vld_q & (md.opa_i == c_a_q) & (md.opb_i == c_b_q) & (div_sgn == c_s_q);
        if (div_zero)     fast_res = is_rem ? md.opa_i : '1;
        else if (div_ovf) fast_res = is_rem ? '0 : md.opa_i;
        else              fast_res = is_rem ? c_r_q : c_q_q;
        q_fin = neg_q  ? -q_nxt : q_nxt;
        r_fin = rneg_q ? -r_nxt : r_nxt;
    end

    iot_riscv_muldiv_div #(.width_p(width_p)) u_div (
        .clk_i      (main_clk_i),
        .rst_an_i   (main_rst_an_i),
        .load_i     (md.req_valid_i & ~md.kill_i & (state_q == MD_IDLE) & ~is_mul),
        .step_i     (state_q == MD_ST_DIV),
        .divisor_i  (b_mag),
        .dividend_i (a_mag),
        .quo_o      (q_nxt),
        .rem_o      (r_nxt)
    );

    if (!mul_seq_p) begin : g_mul_nat
        logic [2*width_p-1:0] a_ext, b_ext, prod;
        assign a_ext   = {{width_p{a_neg}}, md.opa_i};
        assign b_ext   = {{width_p{b_neg}}, md.opb_i};
        assign prod    = a_ext * b_ext;
        assign mul_now = (md.op_i == MD_MUL) ? prod[width_p-1:0] : prod[2*width_p-1:width_p];
        assign mul_fin = '0;
    end else begin : g_mul_seq
        // Shift-add on magnitudes: multiplier sits in the low half and shifts out as the sum shifts in
        logic [2*width_p-1:0] prod_q, prod_nxt, prod_fix;
        logic [width_p-1:0]   mcand_q;
        logic [width_p:0]     psum;
        assign psum     = {1'b0, prod_q[2*width_p-1:width_p]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        assign prod_nxt = {psum, prod_q[width_p-1:1]};
        assign prod_fix = neg_q ? -prod_nxt : prod_nxt;
        assign mul_fin  = (op_q == MD_MUL) ? prod_fix[width_p-1:0] : prod_fix[2*width_p-1:width_p];
        assign mul_now  = '0;
        always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
            if (!main_rst_an_i) begin
                prod_q  <= '0;
                mcand_q <= '0;
            end else if (md.req_valid_i && !md.kill_i && state_q == MD_IDLE && is_mul) begin
                prod_q  <= {{width_p{1'b0}}, b_mag};
                mcand_q <= a_mag;
            end else if (state_q == MD_ST_MUL) begin
                prod_q  <= prod_nxt;
            end
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            c_vld_q   <= 1'b0;
            c_s_q     <= 1'b0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_q_q     <= '0;
            c_r_q     <= '0;
        end else begin
            res_vld_q <= 1'b0;
            if (md.kill_i) begin
                state_q <= MD_IDLE;
                if (state_q == MD_ST_DIV) c_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    MD_IDLE: if (md.req_valid_i) begin
                        op_q   <= md.op_i;
                        opa_q  <= md.opa_i;
                        opb_q  <= md.opb_i;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        cnt_q  <= CW'(width_p);
                        if (is_mul) begin
                            if (mul_seq_p) state_q <= MD_ST_MUL;
                            else begin
                                state_q   <= MD_DONE;
                                res_vld_q <= 1'b1;
                                res_q     <= mul_now;
                            end
                        end else if (div_zero | div_ovf | c_hit) begin
                            state_q   <= MD_DONE;
                            res_vld_q <= 1'b1;
                            res_q     <= fast_res;
                        end else begin
                            state_q <= MD_ST_DIV;
                        end
                    end
                    MD_ST_MUL, MD_ST_DIV: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q   <= MD_DONE;
                            res_vld_q <= 1'b1;
                            if (state_q == MD_ST_MUL) begin
                                res_q <= mul_fin;
                            end else begin
                                res_q   <= op_q[1] ? r_fin : q_fin;
                                c_vld_q <= 1'b1;
                                c_a_q   <= opa_q;
                                c_b_q   <= opb_q;
                                c_s_q   <= ~op_q[0];
                                c_q_q   <= q_fin;
                                c_r_q   <= r_fin;
                            end
                        end
                    end
                    default: state_q <= MD_IDLE;
                endcase
            end
        end
    end

    assign md.req_ready_o = (state_q == MD_IDLE);
    assign md.busy_o      = (state_q == MD_ST_MUL) || (state_q == MD_ST_DIV);
    assign md.res_valid_o = res_vld_q;
    assign md.res_o       = res_q;
endmodule
